// File: rtl/hs_math_basic_pkg.sv
// Basic elaboration-time arithmetic helpers shared across the hs_* blocks.
package hs_math_basic_pkg;

  function automatic int unsigned ceil_to_nxt_pow2(input int unsigned n);
    int unsigned p;
    p = 1;
    while (p < n) p = p << 1;
    return p;
  endfunction

endpackage

// File: rtl/hs_mem_pkg.sv
// Shared types and sizing helpers for the hs_mem RAM family.
package hs_mem_pkg;

  typedef enum logic {
    CLR_IDLE,
    CLR_SWEEP
  } clr_state_e;

  function automatic int unsigned be_width(input int unsigned dw);
    return (dw + 7) / 8;
  endfunction

endpackage

// File: rtl/hs_mem_clr_ctrl.sv
// Clear-sweep controller: after reset or on request, walks every storage entry once.
module hs_mem_clr_ctrl
  import hs_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DEPTH_REAL = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_req,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH_REAL - 1);

  clr_state_e            state;
  clr_state_e            state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLR_SWEEP;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLR_SWEEP) clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
      else                    clr_cnt <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLR_IDLE:  if (clr_req) state_nxt = CLR_SWEEP;
      CLR_SWEEP: if (clr_cnt == LAST_ADDR) state_nxt = CLR_IDLE;
      default:   state_nxt = CLR_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == CLR_SWEEP);
    clr_we   = busy;
    clr_addr = clr_cnt;
  end

endmodule

// File: rtl/hs_mem_mpram_clr.sv
// One-write / N-read RAM with per-byte write enables and a built-in clear sweep.
module hs_mem_mpram_clr
  import hs_math_basic_pkg::*;
  import hs_mem_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           DATA_DEPTH  = 16,
  parameter int unsigned           RD_PORTS    = 2,
  parameter int unsigned           RD_LATENCY  = 0,
  parameter bit                    WR_FIRST    = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
  localparam int unsigned          ADDR_WIDTH  = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1,
  localparam int unsigned          BE_WIDTH    = be_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_req,
  output logic                  busy,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [BE_WIDTH-1:0]   wbe,
  input  logic [RD_PORTS-1:0]   ren,
  input  logic [ADDR_WIDTH-1:0] raddr [RD_PORTS],
  output logic [DATA_WIDTH-1:0] rdata [RD_PORTS]
);

  // A one-entry RAM still gets a 1-bit address, so storage is sized for two.
  localparam int unsigned DEPTH_REAL = ceil_to_nxt_pow2((DATA_DEPTH > 1) ? DATA_DEPTH : 2);

  logic [DATA_WIDTH-1:0] ram [DEPTH_REAL];
  logic [DATA_WIDTH-1:0] be_mask;
  logic [DATA_WIDTH-1:0] wr_word;
  logic                  wr_en;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  hs_mem_clr_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH_REAL (DEPTH_REAL)
  ) u_clr_ctrl (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign wr_en = wen & ~busy;

  always_comb begin
    be_mask = '0;
    for (int unsigned b = 0; b < DATA_WIDTH; b++) be_mask[b] = wbe[b / 8];
    wr_word = (ram[waddr] & ~be_mask) | (wdata & be_mask);
  end

  always_ff @(posedge clk) begin
    if (clr_we)     ram[clr_addr] <= CLEAR_VALUE;
    else if (wr_en) ram[waddr]    <= wr_word;
  end

  if (RD_LATENCY == 0) begin : g_rd_async
    logic ren_unused;
    assign ren_unused = ^ren;

    always_comb begin
      for (int unsigned p = 0; p < RD_PORTS; p++)
        rdata[p] = busy ? CLEAR_VALUE : ram[raddr[p]];
    end
  end else begin : g_rd_sync
    always_ff @(posedge clk) begin
      for (int unsigned p = 0; p < RD_PORTS; p++) begin
        if (rst) begin
          rdata[p] <= CLEAR_VALUE;
        end else if (ren[p]) begin
          if (busy)                                          rdata[p] <= CLEAR_VALUE;
          else if (WR_FIRST && wr_en && (waddr == raddr[p])) rdata[p] <= wr_word;
          else                                               rdata[p] <= ram[raddr[p]];
        end
      end
    end
  end

endmodule

// File: tb/tb_hs_mem_mpram_clr.sv
// Randomised and directed checks of hs_mem_mpram_clr against a behavioural memory model.
module tb_hs_mem_mpram_clr;

  localparam int          DEPTH = 16;
  localparam logic [19:0] CVA   = 20'h000A5;
  localparam logic [7:0]  CVB   = 8'hA5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clr_req;
  logic busy_a, busy_b, busy_c;

  logic        a_wen;
  logic [3:0]  a_waddr;
  logic [19:0] a_wdata;
  logic [2:0]  a_wbe;
  logic [3:0]  a_ren;
  logic [3:0]  a_raddr [4];
  logic [19:0] a_rdata [4];

  logic        b_wen;
  logic [3:0]  b_waddr;
  logic [7:0]  b_wdata;
  logic [0:0]  b_wbe;
  logic [1:0]  b_ren;
  logic [3:0]  b_raddr [2];
  logic [7:0]  b_rdata [2];
  logic [7:0]  c_rdata [2];

  hs_mem_mpram_clr #(
    .DATA_WIDTH (20), .DATA_DEPTH (12), .RD_PORTS (4),
    .RD_LATENCY (0), .WR_FIRST (1'b1), .CLEAR_VALUE (CVA)
  ) u_a (
    .clk (clk), .rst (rst), .clr_req (clr_req), .busy (busy_a),
    .wen (a_wen), .waddr (a_waddr), .wdata (a_wdata), .wbe (a_wbe),
    .ren (a_ren), .raddr (a_raddr), .rdata (a_rdata)
  );

  hs_mem_mpram_clr #(
    .DATA_WIDTH (8), .DATA_DEPTH (16), .RD_PORTS (2),
    .RD_LATENCY (1), .WR_FIRST (1'b1), .CLEAR_VALUE (CVB)
  ) u_b (
    .clk (clk), .rst (rst), .clr_req (clr_req), .busy (busy_b),
    .wen (b_wen), .waddr (b_waddr), .wdata (b_wdata), .wbe (b_wbe),
    .ren (b_ren), .raddr (b_raddr), .rdata (b_rdata)
  );

  hs_mem_mpram_clr #(
    .DATA_WIDTH (8), .DATA_DEPTH (16), .RD_PORTS (2),
    .RD_LATENCY (1), .WR_FIRST (1'b0), .CLEAR_VALUE (CVB)
  ) u_c (
    .clk (clk), .rst (rst), .clr_req (clr_req), .busy (busy_c),
    .wen (b_wen), .waddr (b_waddr), .wdata (b_wdata), .wbe (b_wbe),
    .ren (b_ren), .raddr (b_raddr), .rdata (c_rdata)
  );

  // Reference model: the sweep is unobservable mid-flight (writes dropped,
  // reads masked), so the model fills the whole array when a sweep starts.
  logic [19:0] ma [DEPTH];
  logic [7:0]  mb [DEPTH];
  logic [7:0]  rb_exp [2];
  logic [7:0]  rc_exp [2];
  bit          m_busy = 1'b0;
  int          m_left = 0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] merge(input logic [23:0] old, input logic [23:0] nw,
                                        input logic [2:0] be);
    logic [23:0] r;
    r = old;
    for (int i = 0; i < 3; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  task automatic model_edge();
    bit          was_busy;
    logic [23:0] t;
    was_busy = m_busy;
    for (int p = 0; p < 2; p++) begin
      if (rst) begin
        rb_exp[p] = CVB;
        rc_exp[p] = CVB;
      end else if (b_ren[p]) begin
        if (was_busy) begin
          rb_exp[p] = CVB;
          rc_exp[p] = CVB;
        end else begin
          rb_exp[p] = mb[b_raddr[p]];
          rc_exp[p] = mb[b_raddr[p]];
          if (b_wen && b_waddr == b_raddr[p]) begin
            t = merge({16'h0, mb[b_waddr]}, {16'h0, b_wdata}, {2'b00, b_wbe});
            rb_exp[p] = t[7:0];
          end
        end
      end
    end
    if (!was_busy && a_wen) begin
      t = merge({4'h0, ma[a_waddr]}, {4'h0, a_wdata}, a_wbe);
      ma[a_waddr] = t[19:0];
    end
    if (!was_busy && b_wen) begin
      t = merge({16'h0, mb[b_waddr]}, {16'h0, b_wdata}, {2'b00, b_wbe});
      mb[b_waddr] = t[7:0];
    end
    if (rst || (!was_busy && clr_req)) begin
      m_busy = 1'b1;
      m_left = DEPTH;
      for (int k = 0; k < DEPTH; k++) begin
        ma[k] = CVA;
        mb[k] = CVB;
      end
    end else if (was_busy) begin
      m_left--;
      if (m_left == 0) m_busy = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("busy_a", 32'(busy_a), 32'(m_busy));
    chk("busy_b", 32'(busy_b), 32'(m_busy));
    chk("busy_c", 32'(busy_c), 32'(m_busy));
    for (int p = 0; p < 4; p++)
      chk($sformatf("a_rdata%0d", p), 32'(a_rdata[p]), 32'(m_busy ? CVA : ma[a_raddr[p]]));
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("b_rdata%0d", p), 32'(b_rdata[p]), 32'(rb_exp[p]));
      chk($sformatf("c_rdata%0d", p), 32'(c_rdata[p]), 32'(rc_exp[p]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic count_busy(input string tag);
    int n;
    n = 0;
    while (busy_a === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk(tag, 32'(n), 32'd16);
  endtask

  initial begin
    int n;
    rst = 1'b1; clr_req = 1'b0;
    a_wen = 1'b0; a_waddr = '0; a_wdata = '0; a_wbe = '0; a_ren = '0;
    b_wen = 1'b0; b_waddr = '0; b_wdata = '0; b_wbe = '0; b_ren = '0;
    for (int p = 0; p < 4; p++) a_raddr[p] = '0;
    for (int p = 0; p < 2; p++) b_raddr[p] = '0;
    @(negedge clk);

    // Reset clear: 16 busy cycles, then every entry holds the clear value
    tick();
    rst = 1'b0;
    count_busy("sweep_len_reset");
    b_ren = 2'b11;
    for (int k = 0; k < DEPTH; k++) begin
      for (int p = 0; p < 4; p++) a_raddr[p] = 4'(k);
      for (int p = 0; p < 2; p++) b_raddr[p] = 4'(k);
      tick();
      for (int p = 0; p < 4; p++) chk("clr_val_a", 32'(a_rdata[p]), 32'(CVA));
      for (int p = 0; p < 2; p++) chk("clr_val_b", 32'(b_rdata[p]), 32'(CVB));
    end
    b_ren = 2'b00;

    // Byte enables: middle lane keeps FF from the first write
    a_wen = 1'b1; a_waddr = 4'd3; a_wdata = 20'hFFFFF; a_wbe = 3'b111; tick();
    a_wdata = 20'h12345; a_wbe = 3'b101; tick();
    a_wen = 1'b0; a_raddr[0] = 4'd3; tick();
    chk("be_merge", 32'(a_rdata[0]), 32'h1FF45);

    // Multi-port reads of the same and different addresses
    for (int k = 0; k < 12; k++) begin
      a_wen = 1'b1; a_waddr = 4'(k); a_wdata = 20'(k * 3); a_wbe = 3'b111; tick();
    end
    a_wen = 1'b0;
    a_raddr[0] = 4'd0; a_raddr[1] = 4'd5; a_raddr[2] = 4'd11; a_raddr[3] = 4'd5;
    tick();
    chk("mp_p0", 32'(a_rdata[0]), 32'd0);
    chk("mp_p1", 32'(a_rdata[1]), 32'd15);
    chk("mp_p2", 32'(a_rdata[2]), 32'd33);
    chk("mp_p3", 32'(a_rdata[3]), 32'd15);

    // Read/write collision on the registered ports
    b_wen = 1'b1; b_waddr = 4'd7; b_wdata = 8'h11; b_wbe = 1'b1; tick();
    b_wdata = 8'h22; b_raddr[0] = 4'd7; b_ren = 2'b01; tick();
    chk("coll_wr_first", 32'(b_rdata[0]), 32'h22);
    chk("coll_rd_first", 32'(c_rdata[0]), 32'h11);
    b_wen = 1'b0; b_ren = 2'b00; b_raddr[0] = 4'd3; tick();
    chk("hold_wr_first", 32'(b_rdata[0]), 32'h22);
    chk("hold_rd_first", 32'(c_rdata[0]), 32'h11);

    // Runtime clear: mid-sweep requests ignored, write at cycle 10 dropped
    clr_req = 1'b1; tick();
    clr_req = 1'b0;
    chk("busy_rise", 32'(busy_a), 32'd1);
    n = 0;
    while (busy_a === 1'b1 && n < 40) begin
      n++;
      clr_req = (n == 5 || n == 6);
      a_wen = (n == 10); a_waddr = 4'd5; a_wdata = 20'h0003C; a_wbe = 3'b111;
      b_wen = (n == 10); b_waddr = 4'd5; b_wdata = 8'h3C;
      tick();
    end
    clr_req = 1'b0; a_wen = 1'b0; b_wen = 1'b0;
    chk("sweep_len_pulses", 32'(n), 32'd16);
    a_raddr[0] = 4'd5; b_raddr[0] = 4'd5; b_ren = 2'b01; tick();
    chk("wr_in_clr_a", 32'(a_rdata[0]), 32'(CVA));
    chk("wr_in_clr_b", 32'(b_rdata[0]), 32'(CVB));
    b_ren = 2'b00;

    // Reset at sweep cycle 8 restarts a full sweep
    clr_req = 1'b1; tick();
    clr_req = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    count_busy("sweep_len_restart");

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom % 300 == 0);
      clr_req = ($urandom % 50 == 0);
      a_wen = 1'(($urandom));  a_waddr = 4'($urandom); a_wdata = 20'($urandom); a_wbe = 3'($urandom);
      a_ren = 4'($urandom);
      b_wen = 1'(($urandom));  b_waddr = 4'($urandom); b_wdata = 8'($urandom);  b_wbe = 1'($urandom);
      b_ren = 2'($urandom);
      for (int p = 0; p < 4; p++) a_raddr[p] = 4'($urandom);
      for (int p = 0; p < 2; p++) b_raddr[p] = ($urandom % 3 == 0) ? b_waddr : 4'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
